// File: rtl/le_pkg.sv
// Shared definitions for the line engine: FSM states, DRAM write constants
// and the pixel-to-byte-mask helper.
package le_pkg;

  typedef enum logic [1:0] {
    LE_IDLE,
    LE_SETUP,
    LE_BEAT0,
    LE_BEAT1
  } le_state_e;

  localparam logic [2:0]  LE_CMD_WRITE   = 3'b000;
  localparam int unsigned LE_BURST_ALIGN = 5;
  localparam logic [15:0] LE_MASK_ALL    = 16'hFFFF;

  // Byte mask (1 = keep DRAM contents) for one 128-bit beat of a 32-byte burst.
  // pix is the pixel index inside the burst; only the beat holding it opens a lane.
  function automatic logic [15:0] le_pixel_mask(input logic [2:0] pix, input logic beat);
    logic [15:0] m;
    m = LE_MASK_ALL;
    if (pix[2] == beat) m[{pix[1:0], 2'b00} +: 4] = 4'b0000;
    return m;
  endfunction

endpackage

// File: rtl/le_bresenham_step.sv
// Bresenham stepper: normalises the endpoints on setup (steep swap, left-to-right
// ordering) and advances one pixel per step strobe.
module le_bresenham_step
  import le_pkg::*;
#(
  parameter int unsigned FB_X_BITS = 10,
  parameter int unsigned FB_Y_BITS = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           setup_i,
  input  logic                           step_i,
  input  logic [FB_X_BITS+FB_Y_BITS-1:0] p0_i,
  input  logic [FB_X_BITS+FB_Y_BITS-1:0] p1_i,
  output logic [FB_X_BITS-1:0]           px_o,
  output logic [FB_Y_BITS-1:0]           py_o,
  output logic                           last_o
);

  localparam int unsigned PW = FB_X_BITS + FB_Y_BITS;
  // Steep lines swap axes, so both axes share one internal width.
  localparam int unsigned CW = (FB_X_BITS > FB_Y_BITS) ? FB_X_BITS : FB_Y_BITS;
  localparam int unsigned EW = CW + 2;

  logic [CW-1:0]        ax0, ay0, ax1, ay1, adx, ady;
  logic [CW-1:0]        sx0, sy0, sx1, sy1;
  logic [CW-1:0]        bx0, by0, bx1, by1;
  logic                 steep, yup;
  logic signed [EW-1:0] dx_s, dy_s, err_sub;

  logic [CW-1:0]        x_q, y_q, xend_q;
  logic signed [EW-1:0] dx_q, dy_q, err_q;
  logic                 yup_q, steep_q;

  // Endpoint normalisation evaluated from the latched command points.
  always_comb begin
    ax0   = CW'(p0_i[PW-1:FB_Y_BITS]);
    ay0   = CW'(p0_i[FB_Y_BITS-1:0]);
    ax1   = CW'(p1_i[PW-1:FB_Y_BITS]);
    ay1   = CW'(p1_i[FB_Y_BITS-1:0]);
    adx   = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
    ady   = (ay1 >= ay0) ? ay1 - ay0 : ay0 - ay1;
    steep = ady > adx;
    sx0   = steep ? ay0 : ax0;
    sy0   = steep ? ax0 : ay0;
    sx1   = steep ? ay1 : ax1;
    sy1   = steep ? ax1 : ay1;
    if (sx0 > sx1) begin
      bx0 = sx1; by0 = sy1; bx1 = sx0; by1 = sy0;
    end else begin
      bx0 = sx0; by0 = sy0; bx1 = sx1; by1 = sy1;
    end
    dx_s = EW'(bx1 - bx0);
    dy_s = EW'((by1 >= by0) ? by1 - by0 : by0 - by1);
    yup  = by0 < by1;
  end

  assign err_sub = err_q - dy_q;

  // Walker state: loaded on setup, advanced one column per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      xend_q  <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      yup_q   <= 1'b0;
      steep_q <= 1'b0;
    end else if (setup_i) begin
      x_q     <= bx0;
      y_q     <= by0;
      xend_q  <= bx1;
      dx_q    <= dx_s;
      dy_q    <= dy_s;
      err_q   <= dx_s >>> 1;
      yup_q   <= yup;
      steep_q <= steep;
    end else if (step_i) begin
      x_q <= x_q + CW'(1);
      if (err_sub[EW-1]) begin
        y_q   <= yup_q ? y_q + CW'(1) : y_q - CW'(1);
        err_q <= err_sub + dx_q;
      end else begin
        err_q <= err_sub;
      end
    end
  end

  assign px_o   = steep_q ? y_q[FB_X_BITS-1:0] : x_q[FB_X_BITS-1:0];
  assign py_o   = steep_q ? x_q[FB_Y_BITS-1:0] : y_q[FB_Y_BITS-1:0];
  assign last_o = (x_q == xend_q);

endmodule

// File: rtl/line_engine.sv
// Line engine: command latching, handshake FSM and two-beat DRAM burst packing
// for one pixel per burst.
module line_engine
  import le_pkg::*;
#(
  parameter int unsigned FB_X_BITS = 10,
  parameter int unsigned FB_Y_BITS = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [31:0]                    LE_color,
  input  logic                           LE_color_valid,
  input  logic [FB_X_BITS+FB_Y_BITS-1:0] LE_point,
  input  logic                           LE_point0_valid,
  input  logic                           LE_point1_valid,
  input  logic                           LE_trigger,
  input  logic [31:0]                    LE_frame,
  output logic                           LE_ready,
  input  logic                           af_full,
  input  logic                           wdf_full,
  output logic                           af_wr_en,
  output logic [30:0]                    af_addr_din,
  output logic                           wdf_wr_en,
  output logic [127:0]                   wdf_din,
  output logic [15:0]                    wdf_mask_din
);

  le_state_e                      state_q, state_d;
  logic [31:0]                    color_q;
  logic [FB_X_BITS+FB_Y_BITS-1:0] p0_q, p1_q;
  logic [27:0]                    frame_q;
  logic                           setup, step, last;
  logic [FB_X_BITS-1:0]           px;
  logic [FB_Y_BITS-1:0]           py;
  logic [27:0]                    pix_off, byte_addr;
  logic                           unused_frame_hi;

  assign unused_frame_hi = ^LE_frame[31:28];

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= LE_IDLE;
    else     state_q <= state_d;
  end

  // Command registers accept strobes only while idle; a point1 strobe
  // coinciding with trigger lands here before SETUP reads it.
  always_ff @(posedge clk) begin
    if (state_q == LE_IDLE) begin
      if (LE_color_valid)  color_q <= LE_color;
      if (LE_point0_valid) p0_q    <= LE_point;
      if (LE_point1_valid) p1_q    <= LE_point;
      if (LE_trigger)      frame_q <= LE_frame[27:0];
    end
  end

  // Next-state: one address + beat0 push, then beat1 push, per pixel.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LE_IDLE:  if (LE_trigger) state_d = LE_SETUP;
      LE_SETUP: state_d = LE_BEAT0;
      LE_BEAT0: if (!af_full && !wdf_full) state_d = LE_BEAT1;
      LE_BEAT1: if (!wdf_full) state_d = last ? LE_IDLE : LE_BEAT0;
      default:  state_d = LE_IDLE;
    endcase
  end

  // Outputs and stepper strobes, gated by the FIFO full flags.
  always_comb begin
    LE_ready  = 1'b0;
    af_wr_en  = 1'b0;
    wdf_wr_en = 1'b0;
    setup     = 1'b0;
    step      = 1'b0;
    case (state_q)
      LE_IDLE:  LE_ready = 1'b1;
      LE_SETUP: setup = 1'b1;
      LE_BEAT0: begin
        if (!af_full && !wdf_full) begin
          af_wr_en  = 1'b1;
          wdf_wr_en = 1'b1;
        end
      end
      LE_BEAT1: begin
        if (!wdf_full) begin
          wdf_wr_en = 1'b1;
          step      = !last;
        end
      end
      default: ;
    endcase
  end

  le_bresenham_step #(
    .FB_X_BITS(FB_X_BITS),
    .FB_Y_BITS(FB_Y_BITS)
  ) u_step (
    .clk    (clk),
    .rst    (rst),
    .setup_i(setup),
    .step_i (step),
    .p0_i   (p0_q),
    .p1_i   (p1_q),
    .px_o   (px),
    .py_o   (py),
    .last_o (last)
  );

  assign pix_off      = 28'({py, px, 2'b00});
  assign byte_addr    = frame_q + pix_off;
  assign af_addr_din  = {LE_CMD_WRITE, byte_addr[27:LE_BURST_ALIGN], {LE_BURST_ALIGN{1'b0}}};
  assign wdf_din      = {4{color_q}};
  assign wdf_mask_din = le_pixel_mask(px[2:0], state_q == LE_BEAT1);

endmodule

// File: tb/tb_line_engine.sv
// Directed bench for line_engine: hand-computed burst addresses, masks and
// busy durations for a handful of lines, plus backpressure and reset.
module tb_line_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  LE_color;
  logic         LE_color_valid;
  logic [19:0]  LE_point;
  logic         LE_point0_valid;
  logic         LE_point1_valid;
  logic         LE_trigger;
  logic [31:0]  LE_frame;
  logic         LE_ready;
  logic         af_full;
  logic         wdf_full;
  logic         af_wr_en;
  logic [30:0]  af_addr_din;
  logic         wdf_wr_en;
  logic [127:0] wdf_din;
  logic [15:0]  wdf_mask_din;

  always #5 clk = ~clk;

  line_engine #(
    .FB_X_BITS(10),
    .FB_Y_BITS(10)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .LE_color       (LE_color),
    .LE_color_valid (LE_color_valid),
    .LE_point       (LE_point),
    .LE_point0_valid(LE_point0_valid),
    .LE_point1_valid(LE_point1_valid),
    .LE_trigger     (LE_trigger),
    .LE_frame       (LE_frame),
    .LE_ready       (LE_ready),
    .af_full        (af_full),
    .wdf_full       (wdf_full),
    .af_wr_en       (af_wr_en),
    .af_addr_din    (af_addr_din),
    .wdf_wr_en      (wdf_wr_en),
    .wdf_din        (wdf_din),
    .wdf_mask_din   (wdf_mask_din)
  );

  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;
  int unsigned  ready_low = 0;
  int unsigned  bp_hits   = 0;
  logic         bp_win    = 1'b0;
  logic [30:0]  af_q[$];
  logic [15:0]  mask_q[$];
  logic [127:0] din_q[$];
  logic [30:0]  exp_addr[$];
  logic [15:0]  exp_mask[$];

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Push monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (!LE_ready) ready_low++;
      if (af_wr_en) begin
        af_q.push_back(af_addr_din);
        check_eq("af_push_while_full", af_full | wdf_full, 1'b0);
      end
      if (wdf_wr_en) begin
        mask_q.push_back(wdf_mask_din);
        din_q.push_back(wdf_din);
        check_eq("wdf_push_while_full", wdf_full, 1'b0);
      end
      if (bp_win && (af_wr_en || wdf_wr_en)) bp_hits++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

  task automatic clear_capture();
    af_q.delete();
    mask_q.delete();
    din_q.delete();
    ready_low = 0;
    bp_hits   = 0;
  endtask

  // Load colour and start point, then present end point together with trigger.
  // With bp set, stall BEAT0 via af_full and then BEAT1 via wdf_full.
  task automatic draw(input logic [9:0] x0, input logic [9:0] y0,
                      input logic [9:0] x1, input logic [9:0] y1,
                      input logic [31:0] col, input logic [31:0] frame, input bit bp);
    clear_capture();
    @(posedge clk); #1;
    LE_color        = col;
    LE_color_valid  = 1'b1;
    LE_point        = {x0, y0};
    LE_point0_valid = 1'b1;
    @(posedge clk); #1;
    LE_color_valid  = 1'b0;
    LE_point0_valid = 1'b0;
    LE_point        = {x1, y1};
    LE_point1_valid = 1'b1;
    LE_trigger      = 1'b1;
    LE_frame        = frame;
    @(posedge clk); #1;
    LE_point1_valid = 1'b0;
    LE_trigger      = 1'b0;
    LE_point        = '0;
    if (bp) begin
      af_full = 1'b1;
      bp_win  = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      af_full = 1'b0;
      bp_win  = 1'b0;
      @(posedge clk); #1;
      wdf_full = 1'b1;
      bp_win   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      wdf_full = 1'b0;
      bp_win   = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name, input int unsigned bound);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (LE_ready) begin
        done = 1'b1;
        break;
      end
    end
    check_eq({name, "_idle"}, done, 1'b1);
  endtask

  task automatic verify(input string name, input logic [31:0] col, input int unsigned exp_low);
    int unsigned bad;
    check_eq({name, "_ready_low"}, ready_low, exp_low);
    check_eq({name, "_af_count"}, af_q.size(), exp_addr.size());
    check_eq({name, "_wdf_count"}, mask_q.size(), exp_mask.size());
    for (int i = 0; i < exp_addr.size() && i < af_q.size(); i++)
      check_eq($sformatf("%s_addr%0d", name, i), af_q[i], exp_addr[i]);
    for (int i = 0; i < exp_mask.size() && i < mask_q.size(); i++)
      check_eq($sformatf("%s_mask%0d", name, i), mask_q[i], exp_mask[i]);
    bad = 0;
    foreach (din_q[i]) if (din_q[i] !== {4{col}}) bad++;
    check_eq({name, "_data_bad"}, bad, 0);
  endtask

  initial begin
    int unsigned bad;
    rst = 1'b1;
    LE_color = '0; LE_color_valid = 1'b0; LE_point = '0;
    LE_point0_valid = 1'b0; LE_point1_valid = 1'b0; LE_trigger = 1'b0;
    LE_frame = '0; af_full = 1'b0; wdf_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_af_wr_en", af_wr_en, 1'b0);
    check_eq("reset_wdf_wr_en", wdf_wr_en, 1'b0);
    check_eq("reset_ready", LE_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Horizontal run inside one burst.
    exp_addr = '{31'h0400000, 31'h0400000, 31'h0400000, 31'h0400000};
    exp_mask = '{16'hFFF0, 16'hFFFF, 16'hFF0F, 16'hFFFF, 16'hF0FF, 16'hFFFF, 16'h0FFF, 16'hFFFF};
    draw(10'd0, 10'd0, 10'd3, 10'd0, 32'h00FF0000, 32'h10400000, 1'b0);
    wait_idle("horiz", 50);
    verify("horiz", 32'h00FF0000, 9);

    // Steep vertical line at x=5.
    exp_addr = '{31'h0400000, 31'h0401000, 31'h0402000, 31'h0403000};
    exp_mask = '{16'hFFFF, 16'hFF0F, 16'hFFFF, 16'hFF0F, 16'hFFFF, 16'hFF0F, 16'hFFFF, 16'hFF0F};
    draw(10'd5, 10'd0, 10'd5, 10'd3, 32'h12345678, 32'h10400000, 1'b0);
    wait_idle("steep", 50);
    verify("steep", 32'h12345678, 9);

    // Reversed diagonal; frame upper nibble ignored, base offset 0x40.
    exp_addr = '{31'h0000040, 31'h0001040, 31'h0002040, 31'h0003040};
    exp_mask = '{16'hFFF0, 16'hFFFF, 16'hFF0F, 16'hFFFF, 16'hF0FF, 16'hFFFF, 16'h0FFF, 16'hFFFF};
    draw(10'd3, 10'd3, 10'd0, 10'd0, 32'hA5A5A5A5, 32'hF0000040, 1'b0);
    wait_idle("revdiag", 50);
    verify("revdiag", 32'hA5A5A5A5, 9);

    // Backpressure: 4 stalled BEAT0 cycles plus 3 stalled BEAT1 cycles.
    exp_addr = '{31'h0400000, 31'h0400000, 31'h0400000, 31'h0400000};
    exp_mask = '{16'hFFF0, 16'hFFFF, 16'hFF0F, 16'hFFFF, 16'hF0FF, 16'hFFFF, 16'h0FFF, 16'hFFFF};
    draw(10'd0, 10'd0, 10'd3, 10'd0, 32'h0000FF00, 32'h10400000, 1'b1);
    wait_idle("bp", 80);
    verify("bp", 32'h0000FF00, 16);
    check_eq("bp_window_pushes", bp_hits, 0);

    // Degenerate single pixel.
    exp_addr = '{31'h0402000};
    exp_mask = '{16'hFFFF, 16'h0FFF};
    draw(10'd7, 10'd2, 10'd7, 10'd2, 32'hCAFEF00D, 32'h10400000, 1'b0);
    wait_idle("single", 20);
    verify("single", 32'hCAFEF00D, 3);

    // Reset in the middle of a 100-pixel line, with ignored strobes before it.
    draw(10'd0, 10'd0, 10'd99, 10'd0, 32'h0BADF00D, 32'h10400000, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    LE_color        = 32'hDEADBEEF;
    LE_color_valid  = 1'b1;
    LE_point        = {10'd5, 10'd5};
    LE_point0_valid = 1'b1;
    LE_point1_valid = 1'b1;
    LE_trigger      = 1'b1;
    @(posedge clk); #1;
    LE_color_valid  = 1'b0;
    LE_point0_valid = 1'b0;
    LE_point1_valid = 1'b0;
    LE_trigger      = 1'b0;
    LE_point        = '0;
    rst             = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("postrst_af_wr_en", af_wr_en, 1'b0);
    check_eq("postrst_wdf_wr_en", wdf_wr_en, 1'b0);
    check_eq("postrst_ready", LE_ready, 1'b1);
    clear_capture();
    @(posedge clk); #1;
    LE_trigger = 1'b1;
    @(posedge clk); #1;
    LE_trigger = 1'b0;
    wait_idle("redraw", 400);
    check_eq("redraw_ready_low", ready_low, 201);
    check_eq("redraw_af_count", af_q.size(), 100);
    check_eq("redraw_wdf_count", mask_q.size(), 200);
    if (af_q.size() == 100) begin
      check_eq("redraw_addr_first", af_q[0], 31'h0400000);
      check_eq("redraw_addr_px8", af_q[8], 31'h0400020);
      check_eq("redraw_addr_last", af_q[99], 31'h0400180);
    end
    if (mask_q.size() == 200) begin
      check_eq("redraw_mask_first", mask_q[0], 16'hFFF0);
      check_eq("redraw_mask_last_b0", mask_q[198], 16'h0FFF);
      check_eq("redraw_mask_last_b1", mask_q[199], 16'hFFFF);
    end
    bad = 0;
    foreach (din_q[i]) if (din_q[i] !== {4{32'h0BADF00D}}) bad++;
    check_eq("redraw_data_bad", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
